// File: rtl/cdb_arbiter_pkg.sv
// Shared types and the ROB age compare for the CDB writeback arbiter.
// Latency and backpressure are not applicable: types and functions only.
package cdb_arbiter_pkg;

    localparam int CDB_DATA_W    = 32;
    localparam int CDB_PREG_W    = 7;
    localparam int CDB_ROB_W     = 5;
    localparam int CDB_ROB_MAX_W = 16;

    typedef enum logic [1:0] {
        CDB_ALU = 2'd0,
        CDB_B   = 2'd1,
        CDB_MEM = 2'd2
    } cdb_src_e;

    typedef struct packed {
        logic                  valid;
        logic [CDB_PREG_W-1:0] pd;
        logic [CDB_ROB_W-1:0]  rob;
        logic [CDB_DATA_W-1:0] data;
        cdb_src_e              src;
    } cdb_data_t;

    // Ages are taken relative to the ROB head modulo 2**w, so index wrap is harmless.
    function automatic logic rob_younger(input logic [CDB_ROB_MAX_W-1:0] idx,
                                         input logic [CDB_ROB_MAX_W-1:0] tag,
                                         input logic [CDB_ROB_MAX_W-1:0] head,
                                         input int                       w);
        logic [CDB_ROB_MAX_W-1:0] mask;
        mask = (CDB_ROB_MAX_W'(1) << w) - CDB_ROB_MAX_W'(1);
        return ((idx - head) & mask) > ((tag - head) & mask);
    endfunction

endpackage

// File: rtl/cdb_arbiter_wb_queue.sv
// Per-source in-order result queue; flush removes younger entries and compacts in the same edge.
// Head is visible combinationally after flush filtering; ready drops when full, with no pass-through.
module wb_queue
    import cdb_arbiter_pkg::*;
#(
    parameter int PREG_W = CDB_PREG_W,
    parameter int ROB_W  = CDB_ROB_W,
    parameter int DATA_W = CDB_DATA_W,
    parameter int QDEPTH = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            push_i,
    input  logic [PREG_W+ROB_W+DATA_W-1:0]  push_dat_i,
    input  logic                            pop_i,
    input  logic                            flush_i,
    input  logic [ROB_W-1:0]                flush_tag_i,
    input  logic [ROB_W-1:0]                rob_head_i,
    output logic                            ready_o,
`ifdef CDB_BYPASS_EN
    output logic                            empty_o,
`endif
    output logic                            head_vld_o,
    output logic [PREG_W+ROB_W+DATA_W-1:0]  head_dat_o
);
    localparam int W = PREG_W + ROB_W + DATA_W;

    logic [QDEPTH-1:0] vld_q, vld_d;
    logic [W-1:0]      dat_q [QDEPTH];
    logic [W-1:0]      dat_d [QDEPTH];
    logic [QDEPTH-1:0] keep;
    int                rank [QDEPTH];
    int                n_keep;
    logic [QDEPTH:0]   cmp_vld;
    logic [W-1:0]      cmp_dat [QDEPTH+1];
    logic              push_ok;

    function automatic logic younger(input logic [ROB_W-1:0] rob);
        return flush_i && rob_younger(CDB_ROB_MAX_W'(rob), CDB_ROB_MAX_W'(flush_tag_i),
                                      CDB_ROB_MAX_W'(rob_head_i), ROB_W);
    endfunction

    assign ready_o    = !reset && !vld_q[QDEPTH-1];
`ifdef CDB_BYPASS_EN
    assign empty_o    = !vld_q[0];
`endif
    assign head_vld_o = cmp_vld[0];
    assign head_dat_o = cmp_dat[0];
    assign push_ok    = push_i && ready_o && !younger(push_dat_i[DATA_W +: ROB_W]);

    always_comb begin
        n_keep = 0;
        for (int i = 0; i < QDEPTH; i++) begin
            keep[i] = vld_q[i] && !younger(dat_q[i][DATA_W +: ROB_W]);
            rank[i] = n_keep;
            n_keep  = n_keep + int'(keep[i]);
        end
    end

    // Survivor with rank j lands in slot j; the extra slot stays empty to feed the pop shift.
    always_comb begin
        cmp_vld = '0;
        for (int j = 0; j <= QDEPTH; j++) cmp_dat[j] = '0;
        for (int j = 0; j < QDEPTH; j++) begin
            for (int i = j; i < QDEPTH; i++) begin
                if (keep[i] && rank[i] == j) begin
                    cmp_vld[j] = 1'b1;
                    cmp_dat[j] = dat_q[i];
                end
            end
        end
    end

    always_comb begin
        for (int j = 0; j < QDEPTH; j++) begin
            vld_d[j] = pop_i ? cmp_vld[j+1] : cmp_vld[j];
            dat_d[j] = pop_i ? cmp_dat[j+1] : cmp_dat[j];
            if (push_ok && j == n_keep - int'(pop_i)) begin
                vld_d[j] = 1'b1;
                dat_d[j] = push_dat_i;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q <= '0;
            for (int j = 0; j < QDEPTH; j++) dat_q[j] <= '0;
        end else begin
            vld_q <= vld_d;
            for (int j = 0; j < QDEPTH; j++) dat_q[j] <= dat_d[j];
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin CDB writeback arbiter over ALU/branch/mem queues; 2-cycle latency (1 with CDB_BYPASS_EN).
// Sources are backpressured per queue via *_ready; one broadcast per cycle, younger results squashed on flush.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int DATA_W = CDB_DATA_W,
    parameter int PREG_W = CDB_PREG_W,
    parameter int ROB_W  = CDB_ROB_W,
    parameter int QDEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [PREG_W-1:0] alu_pd,
    input  logic [ROB_W-1:0]  alu_rob,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [PREG_W-1:0] b_pd,
    input  logic [ROB_W-1:0]  b_rob,
    input  logic [DATA_W-1:0] b_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [PREG_W-1:0] mem_pd,
    input  logic [ROB_W-1:0]  mem_rob,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [ROB_W-1:0]  rob_head,
    input  logic              flush,
    input  logic [ROB_W-1:0]  flush_tag,
    output logic              cdb_valid,
    output logic [PREG_W-1:0] cdb_pd,
    output logic [ROB_W-1:0]  cdb_rob,
    output logic [DATA_W-1:0] cdb_data,
    output logic [1:0]        cdb_src
);
    localparam int W = PREG_W + ROB_W + DATA_W;

    logic [2:0]   in_vld, q_rdy, q_head_vld, q_push, q_pop, cand, byp;
    logic [W-1:0] in_dat [3];
    logic [W-1:0] q_head_dat [3];
    logic [W-1:0] win_dat;
    logic         win_vld;
    logic [1:0]   win_src, scan;
    logic [1:0]   rr_q, rr_d;

    logic              cdb_valid_q, cdb_valid_d;
    logic [PREG_W-1:0] cdb_pd_q, cdb_pd_d;
    logic [ROB_W-1:0]  cdb_rob_q, cdb_rob_d;
    logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
    logic [1:0]        cdb_src_q, cdb_src_d;

    assign in_vld    = {mem_valid, b_valid, alu_valid};
    assign in_dat[0] = {alu_pd, alu_rob, alu_data};
    assign in_dat[1] = {b_pd, b_rob, b_data};
    assign in_dat[2] = {mem_pd, mem_rob, mem_data};
    assign {mem_ready, b_ready, alu_ready} = q_rdy;

`ifdef CDB_BYPASS_EN
    logic [2:0] q_empty, in_live;

    always_comb begin
        for (int s = 0; s < 3; s++) begin
            in_live[s] = in_vld[s] && q_rdy[s] &&
                         !(flush && rob_younger(CDB_ROB_MAX_W'(in_dat[s][DATA_W +: ROB_W]),
                                                CDB_ROB_MAX_W'(flush_tag),
                                                CDB_ROB_MAX_W'(rob_head), ROB_W));
        end
    end

    assign cand = q_head_vld | (q_empty & in_live);
`else
    assign cand = q_head_vld;
`endif

    for (genvar g = 0; g < 3; g++) begin : g_q
        wb_queue #(
            .PREG_W (PREG_W),
            .ROB_W  (ROB_W),
            .DATA_W (DATA_W),
            .QDEPTH (QDEPTH)
        ) u_q (
            .clk         (clk),
            .reset       (reset),
            .push_i      (q_push[g]),
            .push_dat_i  (in_dat[g]),
            .pop_i       (q_pop[g]),
            .flush_i     (flush),
            .flush_tag_i (flush_tag),
            .rob_head_i  (rob_head),
            .ready_o     (q_rdy[g]),
`ifdef CDB_BYPASS_EN
            .empty_o     (q_empty[g]),
`endif
            .head_vld_o  (q_head_vld[g]),
            .head_dat_o  (q_head_dat[g])
        );
    end

    // rr_q holds the source with highest priority this cycle.
    always_comb begin
        win_vld = 1'b0;
        win_src = CDB_ALU;
        scan    = rr_q;
        for (int k = 0; k < 3; k++) begin
            if (!win_vld && cand[scan]) begin
                win_vld = 1'b1;
                win_src = scan;
            end
            scan = (scan == 2'd2) ? 2'd0 : scan + 2'd1;
        end
    end

    always_comb begin
        for (int s = 0; s < 3; s++) begin
            q_pop[s]  = win_vld && win_src == 2'(s) && q_head_vld[s];
            byp[s]    = win_vld && win_src == 2'(s) && !q_head_vld[s];
            q_push[s] = in_vld[s] && q_rdy[s] && !byp[s];
        end
        win_dat = q_head_vld[win_src] ? q_head_dat[win_src] : in_dat[win_src];
    end

    always_comb begin
        cdb_valid_d = win_vld;
        cdb_pd_d    = cdb_pd_q;
        cdb_rob_d   = cdb_rob_q;
        cdb_data_d  = cdb_data_q;
        cdb_src_d   = cdb_src_q;
        rr_d        = rr_q;
        if (win_vld) begin
            {cdb_pd_d, cdb_rob_d, cdb_data_d} = win_dat;
            cdb_src_d = win_src;
            rr_d      = (win_src == 2'd2) ? 2'd0 : win_src + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cdb_valid_q <= 1'b0;
            cdb_pd_q    <= '0;
            cdb_rob_q   <= '0;
            cdb_data_q  <= '0;
            cdb_src_q   <= '0;
            rr_q        <= CDB_ALU;
        end else begin
            cdb_valid_q <= cdb_valid_d;
            cdb_pd_q    <= cdb_pd_d;
            cdb_rob_q   <= cdb_rob_d;
            cdb_data_q  <= cdb_data_d;
            cdb_src_q   <= cdb_src_d;
            rr_q        <= rr_d;
        end
    end

    assign cdb_valid = cdb_valid_q;
    assign cdb_pd    = cdb_pd_q;
    assign cdb_rob   = cdb_rob_q;
    assign cdb_data  = cdb_data_q;
    assign cdb_src   = cdb_src_q;

endmodule
